// File: rtl/data_mgr_pkg.sv
// rtl/data_mgr_pkg.sv - shared sizing, state encoding and modulo-DEPTH pointer helpers
package data_mgr_pkg;

    localparam int DEPTH        = 7;
    localparam int DATA_WIDTH   = 32;
    localparam int RETIRE_BATCH = 4;
    localparam int PTR_W        = $clog2(DEPTH);
    localparam int CNT_W        = $clog2(DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        RECOVER = 2'd1,
        ABORT   = 2'd2
    } state_e;

    // Next id, wrapping DEPTH-1 back to 0 (DEPTH need not be a power of two).
    function automatic ptr_t ptr_inc(input ptr_t p);
        ptr_inc = (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    // Forward distance from b to a around the ring.
    function automatic cnt_t ptr_dist(input ptr_t a, input ptr_t b);
        if (a >= b)
            ptr_dist = cnt_t'(a) - cnt_t'(b);
        else
            ptr_dist = cnt_t'(a) + cnt_t'(DEPTH) - cnt_t'(b);
    endfunction

    // Advance a pointer by n < DEPTH steps around the ring.
    function automatic ptr_t ptr_add(input ptr_t p, input cnt_t n);
        int s;
        s = int'(p) + int'(n);
        if (s >= DEPTH)
            s = s - DEPTH;
        ptr_add = ptr_t'(s);
    endfunction

endpackage

// File: rtl/retire_ptr_ctrl.sv
// rtl/retire_ptr_ctrl.sv - pending-retire counter and published retire pointer (RETIRE_BATCH_EN selects batching)
module retire_ptr_ctrl
    import data_mgr_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic retire,
    input  logic recover,
    input  logic out_vld,
    output cnt_t pending,
    output cnt_t publish,
    output ptr_t retire_ptr
);

    logic do_pub;

`ifdef RETIRE_BATCH_EN
    // Publish a full batch, flush when the sink side goes idle so a full
    // buffer can never stall on unpublished retires, and always flush before abort.
    assign do_pub = (pending != '0) &&
                    ((pending >= cnt_t'(RETIRE_BATCH)) || !out_vld || recover);
`else
    logic unused_ok;
    assign unused_ok = out_vld ^ recover;
    // Every retirement is made visible the cycle after its sink handshake.
    assign do_pub = (pending != '0);
`endif

    assign publish = do_pub ? pending : '0;

    // Pending count and published pointer advance together so the pair stays consistent.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending    <= '0;
            retire_ptr <= '0;
        end else begin
            pending <= pending - publish + cnt_t'(retire);
            if (do_pub)
                retire_ptr <= ptr_add(retire_ptr, pending);
        end
    end

    // A retire jump can never exceed one batch.
    assert property (@(posedge clk) disable iff (!reset_n) pending <= cnt_t'(RETIRE_BATCH));

endmodule

// File: rtl/data_retire_unit.sv
// rtl/data_retire_unit.sv - id-indexed retire buffer with in-order sink delivery and nack replay (RETIRE_BATCH_EN)
module data_retire_unit
    import data_mgr_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [PTR_W-1:0]      data_id_i,
    output logic [PTR_W-1:0]      retire_ptr_o,
    output logic                  abort_vld_o,
    output logic [PTR_W-1:0]      abort_id_o,
    output logic [DATA_WIDTH-1:0] abort_data_o,
    output logic                  out_vld_o,
    input  logic                  out_ready_i,
    input  logic                  out_nack_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [PTR_W-1:0]      out_id_o
);

    state_e state, state_next;
    ptr_t   head, tail;
    cnt_t   cnt, pending, publish, unsent;
    logic   store, hs, nack, sent;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign hs     = out_vld_o && out_ready_i;
    assign nack   = hs && out_nack_i;
    assign sent   = hs && !out_nack_i;
    assign unsent = cnt - pending;

    assign out_data_o = mem[head];
    assign out_id_o   = head;

    retire_ptr_ctrl u_retire_ptr_ctrl (
        .clk        (clk),
        .reset_n    (reset_n),
        .retire     (sent),
        .recover    (state == RECOVER),
        .out_vld    (out_vld_o),
        .pending    (pending),
        .publish    (publish),
        .retire_ptr (retire_ptr_o)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= RUN;
        else
            state <= state_next;
    end

    // A nack walks RUN -> RECOVER -> ABORT -> RUN, one cycle per step.
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (nack) state_next = RECOVER;
            RECOVER: state_next = ABORT;
            ABORT:   state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Outside RUN the upstream is always drained so it can see the abort cleanly.
    always_comb begin
        ready_o   = 1'b1;
        out_vld_o = 1'b0;
        store     = 1'b0;
        if (state == RUN) begin
            ready_o   = (cnt < cnt_t'(DEPTH));
            out_vld_o = (unsent != '0);
            store     = valid_i && ready_o;
        end
    end

    // Ring pointers and occupancy; ABORT rewinds the tail to the replay point.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (state == ABORT) begin
                tail <= head;
                cnt  <= '0;
            end else begin
                if (store)
                    tail <= ptr_inc(tail);
                cnt <= cnt + cnt_t'(store) - publish;
            end
            if (sent)
                head <= ptr_inc(head);
        end
    end

    // Payload storage, indexed by beat id.
    always_ff @(posedge clk) begin
        if (store)
            mem[data_id_i] <= data_i;
    end

    // Abort is raised for the ABORT cycle, carrying the rejected beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            abort_vld_o  <= 1'b0;
            abort_id_o   <= '0;
            abort_data_o <= '0;
        end else begin
            abort_vld_o <= (state == RECOVER);
            if (state == RECOVER) begin
                abort_id_o   <= head;
                abort_data_o <= mem[head];
            end
        end
    end

    // Upstream must deliver ids strictly in ring order.
    assert property (@(posedge clk) disable iff (!reset_n) store |-> (data_id_i == tail));

    // Beats between the retire pointer and head are exactly the unpublished retires.
    assert property (@(posedge clk) disable iff (!reset_n) ptr_dist(head, retire_ptr_o) == pending);

endmodule
